// File: rtl/imsic_msi_receiver.sv
// Purpose: IMSIC receive side; MSI writes set pending bits in per-hart M/S/VS interrupt files. Optional drop counter under IMSIC_DROP_CNT_EN.
// Latency: MSI accepted at edge E0 sets eip at E1; o_topei/o_irq show it at E2. Enable writes and claims show one edge later.
// Backpressure: 2-entry input FIFO drains one entry per cycle, so o_msi_ready only drops if the FIFO fills.
module imsic_msi_receiver #(
    parameter int NR_SRC      = 64,
    parameter int NR_HARTS    = 2,
    parameter int NR_VS_FILES = 1,
    parameter int NR_FILES    = 2 + NR_VS_FILES,
    parameter int ID_W        = $clog2(NR_SRC),
    parameter int FILE_IDX_W  = $clog2(NR_HARTS * NR_FILES)
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_msi_valid,
    output logic                              o_msi_ready,
    input  logic [FILE_IDX_W-1:0]             i_msi_page,
    input  logic [31:0]                       i_msi_data,
    input  logic                              i_eie_we,
    input  logic [FILE_IDX_W-1:0]             i_eie_page,
    input  logic [ID_W-1:0]                   i_eie_id,
    input  logic                              i_eie_val,
    input  logic                              i_claim,
    input  logic [FILE_IDX_W-1:0]             i_claim_page,
`ifdef IMSIC_DROP_CNT_EN
    output logic [15:0]                       o_drop_cnt,
`endif
    output logic [NR_HARTS*NR_FILES*ID_W-1:0] o_topei,
    output logic [NR_HARTS*NR_FILES-1:0]      o_irq
);

    localparam int NR_TOT = NR_HARTS * NR_FILES;

    // Input FIFO state
    logic [FILE_IDX_W-1:0] fifo_page [2];
    logic [31:0]           fifo_dat  [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            fifo_cnt;
    logic                  push;
    logic                  pop;

    // Decoded pop and claim
    logic [FILE_IDX_W-1:0] pop_page;
    logic [31:0]           pop_dat;
    logic                  pop_ok;
    logic                  pop_drop;
    logic [ID_W-1:0]       claim_id;
    logic                  claim_ok;

    // Interrupt file state
    logic [NR_SRC-1:0]     eip     [NR_TOT];
    logic [NR_SRC-1:0]     eie     [NR_TOT];
    logic [NR_SRC-1:0]     eip_nxt [NR_TOT];
    logic [ID_W-1:0]       topei_q   [NR_TOT];
    logic [ID_W-1:0]       topei_nxt [NR_TOT];
    logic [NR_TOT-1:0]     irq_q;

    assign o_msi_ready = (fifo_cnt != 2'd2);
    assign push        = i_msi_valid && o_msi_ready;
    assign pop         = (fifo_cnt != 2'd0);
    assign pop_page    = fifo_page[rd_ptr];
    assign pop_dat     = fifo_dat[rd_ptr];

    // Identity 0, identities beyond NR_SRC and nonexistent pages are dropped
    assign pop_ok   = pop && (pop_dat != 32'd0) && (pop_dat < 32'(NR_SRC))
                          && (32'(pop_page) < 32'(NR_TOT));
    assign pop_drop = pop && !pop_ok;

    // FIFO storage: data regs need no reset, occupancy tracking does
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_page[wr_ptr] <= i_msi_page;
            fifo_dat[wr_ptr]  <= i_msi_data;
        end
    end

    // FIFO pointers and occupancy; reset discards anything in flight
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Claim targets the identity currently shown; out-of-range pages yield 0
    always_comb begin
        claim_id = '0;
        for (int f = 0; f < NR_TOT; f++) begin
            if (i_claim_page == FILE_IDX_W'(f)) claim_id = topei_q[f];
        end
    end

    assign claim_ok = i_claim && (claim_id != '0);

    // Pending update: claim clear first so a same-bit MSI set overrides it
    always_comb begin
        for (int f = 0; f < NR_TOT; f++) eip_nxt[f] = eip[f];
        if (claim_ok) eip_nxt[i_claim_page][claim_id] = 1'b0;
        if (pop_ok)   eip_nxt[pop_page][pop_dat[ID_W-1:0]] = 1'b1;
    end

    // Pending and enable arrays
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int f = 0; f < NR_TOT; f++) begin
                eip[f] <= '0;
                eie[f] <= '0;
            end
        end else begin
            for (int f = 0; f < NR_TOT; f++) eip[f] <= eip_nxt[f];
            if (i_eie_we && (i_eie_id != '0) && (32'(i_eie_page) < 32'(NR_TOT)))
                eie[i_eie_page][i_eie_id] <= i_eie_val;
        end
    end

    // Lowest enabled-pending identity per file; scanning downward lets the lowest win
    always_comb begin
        for (int f = 0; f < NR_TOT; f++) begin
            topei_nxt[f] = '0;
            for (int i = NR_SRC - 1; i >= 1; i--) begin
                if (eip[f][i] && eie[f][i]) topei_nxt[f] = ID_W'(i);
            end
        end
    end

    // Registered top identity and IRQ lines
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int f = 0; f < NR_TOT; f++) topei_q[f] <= '0;
            irq_q <= '0;
        end else begin
            for (int f = 0; f < NR_TOT; f++) begin
                topei_q[f] <= topei_nxt[f];
                irq_q[f]   <= (topei_nxt[f] != '0);
            end
        end
    end

    for (genvar g = 0; g < NR_TOT; g++) begin : g_topei
        assign o_topei[g*ID_W +: ID_W] = topei_q[g];
    end
    assign o_irq = irq_q;

`ifdef IMSIC_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    // Saturating count of discarded MSIs
    always_ff @(posedge i_clk) begin
        if (i_rst)                                  drop_cnt_q <= 16'd0;
        else if (pop_drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end

    assign o_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: doc/imsic_msi_receiver.md
Name: imsic_msi_receiver

Overview:
- Receiving end of the APLIC MSI path: accepts MSI writes (the APLIC in DOMAIN_IN_MSI_MODE issues these) and sets pending bits in per-hart interrupt files (M, S, NR_VS_FILES × VS).
- Holds pending (eip) and enable (eie) arrays. Presents a registered top interrupt identity and IRQ line per file to the hart CSR logic. Supports a claim handshake.

Parameters:
- NR_SRC, 64, interrupt identities per file; identity 0 is reserved/invalid.
- NR_HARTS, 2, harts served.
- NR_VS_FILES, 1, guest files per hart; NR_FILES = 2 + NR_VS_FILES. File 0 = M, file 1 = S, files 2.. = VS.
- ID_W, $clog2(NR_SRC), identity width.
- FILE_IDX_W, $clog2(NR_HARTS*NR_FILES), page index width.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_msi_valid  in  1  MSI write request
- o_msi_ready  out  1  request accepted when valid&ready
- i_msi_page  in  FILE_IDX_W  target file = hart*NR_FILES + file
- i_msi_data  in  32  seteipnum value (EIID)
- i_eie_we  in  1  enable-bit write strobe
- i_eie_page  in  FILE_IDX_W  target file for the enable write
- i_eie_id  in  ID_W  identity
- i_eie_val  in  1  new enable value
- i_claim  in  1  claim strobe for i_claim_page
- i_claim_page  in  FILE_IDX_W  file being claimed
- o_topei  out  NR_HARTS*NR_FILES*ID_W  per-file top enabled-pending identity; 0 = none
- o_irq  out  NR_HARTS*NR_FILES  per-file: o_topei != 0

Behaviour:
- Reset (synchronous, i_rst=1 at edge):
  - eip = 0, eie = 0, FIFO empty.
  - o_msi_ready = 1, o_topei = 0, o_irq = 0.
  - In-flight MSIs are discarded.
- Input buffer: 2-entry FIFO of {page, data}.
  - o_msi_ready = !full.
  - Push on valid&ready. One pop per cycle when non-empty.
  - A simultaneous push and pop when full is not possible, because ready = 0 when full.
  - Push and pop in the same cycle are allowed when 1 entry is occupied.
- Pop/decode: the MSI is dropped (no state change) when data == 0, data >= NR_SRC, or page >= NR_HARTS*NR_FILES. Otherwise eip[page][data] is set.
- Latency:
  - MSI accepted at edge E0 into an empty FIFO → eip set at E1 → o_topei/o_irq reflect at E2.
  - Back-to-back MSIs sustain 1 per cycle.
- Enable write: eie[page][id] = val at the i_eie_we edge. o_topei reflects it on the next edge. id 0 writes are ignored.
- Top identity: per file, the lowest-numbered i with eip & eie set. The value is registered each cycle from the current eip/eie.
- Claim: at the i_claim edge, eip[i_claim_page][o_topei[i_claim_page]] is cleared, using the value currently shown. If that value is 0 the claim has no effect. The new top appears one edge later.
- Same edge, same file and bit:
  - Popped MSI set and claim clear: set wins, bit stays pending.
  - MSI set on a disabled bit: bit is pending, no IRQ until enabled.
- Duplicate MSI to an already-pending identity is idempotent.

Optional Feature:
- Macro: IMSIC_DROP_CNT_EN.
- Defined: adds output o_drop_cnt[15:0]. It increments on every dropped MSI (invalid EIID or page), saturates at 16'hFFFF, and resets to 0.
- Undefined: no counter and no port. Dropped MSIs are silently discarded.

Test Plan:
- Reset with i_rst=1 for 2 cycles → o_msi_ready=1, all o_topei=0, o_irq=0.
- eie[page 1][5]=1, then MSI page 1 data 5 at E0 → o_irq[1]=1 and o_topei[1]=5 exactly at E2; other files stay 0.
- MSIs data 9 then 3 to page 0 with both enabled → topei=3. Claim → topei=9 the next cycle. Claim → topei=0, o_irq[0]=0.
- Hold i_msi_valid for 4 cycles with data 7,8,9,10 → all four accepted. Ready never drops because 1 pop per cycle. Force a stall by asserting reset mid-burst → FIFO flushed, no bits set.
- MSI data 0, data 64, and page 6 (with NR_HARTS=2, NR_FILES=3) → no pending change. With IMSIC_DROP_CNT_EN, o_drop_cnt=3.
- Pending id 4, topei=4; a popped MSI id 4 and a claim on the same edge → topei stays 4 next cycle.
